uart_rx: RTL and testbench

Asynchronous serial receiver, the receive-side counterpart of the team's `uart_tx`. It samples a UART line (one start bit, DATA_WIDTH data bits LSB first, one stop bit, no parity) at the centre of each bit and delivers each word on a ready/valid output port. It flags framing errors and overruns, and sits between the board RX pin and the on-chip consumer (FIFO or command decoder).

---
 rtl/uart_rx_if.sv | 10 +
 rtl/uart_rx.sv | 126 ++++++++++++
 tb/tb_uart_rx.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// uart_rx_if: ready/valid word port between the UART receiver and its consumer
interface uart_rx_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  ready;
    modport master (output data, valid, input ready);
    modport slave  (input data, valid, output ready);
endinterface

// File: rtl/uart_rx.sv
// uart_rx: mid-bit sampling UART receiver (start, DATA_WIDTH LSB-first bits, stop) with frame/overrun flags
module uart_rx #(
    parameter int DATA_WIDTH = 8,
    parameter int BAUD_RATE  = 115200,
    parameter int CLK_FREQ   = 100_000_000
) (
    input  logic      clk,
    input  logic      rstn,
    input  logic      sig,
    uart_rx_if.master rx,
    output logic      err_frame,
    output logic      err_overrun
);
    localparam int PULSE_WIDTH      = CLK_FREQ / BAUD_RATE;
    localparam int HALF_PULSE_WIDTH = PULSE_WIDTH / 2;
    localparam int CW               = $clog2(PULSE_WIDTH) + 1;
    localparam int IW               = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(PULSE_WIDTH - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(HALF_PULSE_WIDTH - 1);
    localparam logic [IW-1:0] LAST    = IW'(DATA_WIDTH - 1);

    if (PULSE_WIDTH < 4) begin : g_pulse_width_check
        $error("uart_rx: CLK_FREQ/BAUD_RATE must be at least 4");
    end

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

    state_t                state_q, state_d;
    logic [1:0]            sync_q, sync_d;
    logic [1:0]            warm_q, warm_d;
    logic                  prev_q, prev_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  err_frame_q, err_frame_d;
    logic                  err_overrun_q, err_overrun_d;
    logic                  s, tick, slot_free;

    assign s           = sync_q[1];
    assign tick        = cnt_q == '0;
    assign slot_free   = !valid_q || rx.ready;
    assign rx.data     = data_q;
    assign rx.valid    = valid_q;
    assign err_frame   = err_frame_q;
    assign err_overrun = err_overrun_q;

    // prev only tracks s once the reset-forced 1s have left the synchronizer,
    // so a line already low at reset release is not taken as a start edge
    always_comb begin
        sync_d        = {sync_q[0], sig};
        warm_d        = {warm_q[0], 1'b1};
        prev_d        = s & warm_q[1];
        state_d       = state_q;
        cnt_d         = (state_q != S_IDLE && !tick) ? cnt_q - 1'b1 : cnt_q;
        idx_d         = idx_q;
        shift_d       = shift_q;
        data_d        = data_q;
        valid_d       = valid_q & ~rx.ready;
        err_frame_d   = 1'b0;
        err_overrun_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (prev_q && !s) begin
                    state_d = S_START;
                    cnt_d   = HALF_M1;
                end
            end
            S_START: begin
                if (tick) begin
                    state_d = s ? S_IDLE : S_DATA;
                    idx_d   = '0;
                    cnt_d   = FULL_M1;
                end
            end
            S_DATA: begin
                if (tick) begin
                    shift_d = DATA_WIDTH'({s, shift_q} >> 1);
                    idx_d   = idx_q + 1'b1;
                    cnt_d   = FULL_M1;
                    state_d = (idx_q == LAST) ? S_STOP : S_DATA;
                end
            end
            S_STOP: begin
                if (tick) begin
                    state_d       = s ? S_IDLE : S_BREAK;
                    err_frame_d   = !s;
                    err_overrun_d = s && !slot_free;
                    data_d        = (s && slot_free) ? shift_q : data_q;
                    valid_d       = (s && slot_free) ? 1'b1 : valid_d;
                end
            end
            S_BREAK: state_d = s ? S_IDLE : S_BREAK;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q       <= S_IDLE;
            sync_q        <= 2'b11;
            warm_q        <= '0;
            prev_q        <= 1'b0;
            cnt_q         <= '0;
            idx_q         <= '0;
            shift_q       <= '0;
            data_q        <= '0;
            valid_q       <= 1'b0;
            err_frame_q   <= 1'b0;
            err_overrun_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            sync_q        <= sync_d;
            warm_q        <= warm_d;
            prev_q        <= prev_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            shift_q       <= shift_d;
            data_q        <= data_d;
            valid_q       <= valid_d;
            err_frame_q   <= err_frame_d;
            err_overrun_q <= err_overrun_d;
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames at 10 clk/bit; a negedge monitor checks words and error pulses against a queue
module tb_uart_rx;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic sig = 1'b1;
    logic err_frame, err_overrun;

    uart_rx_if #(.DATA_WIDTH(8)) rx();

    uart_rx #(
        .DATA_WIDTH(8),
        .BAUD_RATE(100_000),
        .CLK_FREQ(1_000_000)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .sig(sig),
        .rx(rx),
        .err_frame(err_frame),
        .err_overrun(err_overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         kind;
        logic [7:0] d;
    } ev_t;

    ev_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    int  word_cyc = -1;
    int  t0;
    bit  pv = 1'b0;
    bit  phs = 1'b0;

    task automatic expect_ev(input int kind, input logic [7:0] d);
        ev_t e;
        e.kind = kind;
        e.d    = d;
        exp_q.push_back(e);
    endtask

    task automatic got(input int kind, input logic [7:0] d);
        ev_t e;
        n_cmp++;
        if (kind == 0) word_cyc = cyc;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL event: got kind=%0d data=%02h, expected no event", kind, d);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || (kind == 0 && e.d != d)) begin
                n_bad++;
                $display("FAIL event: got kind=%0d data=%02h, expected kind=%0d data=%02h", kind, d, e.kind, e.d);
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // kind 0 = word, 1 = err_frame, 2 = err_overrun
    always @(negedge clk) begin
        if (rx.valid && (!pv || phs)) got(0, rx.data);
        if (err_frame) got(1, 8'h00);
        if (err_overrun) got(2, 8'h00);
        pv  = rx.valid;
        phs = rx.valid && rx.ready;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic send(input logic [7:0] d, input logic stop);
        sig = 1'b0;
        tick(10);
        for (int i = 0; i < 8; i++) begin
            sig = d[i];
            tick(10);
        end
        sig = stop;
        tick(10);
    endtask

    initial begin
        rx.ready = 1'b1;
        tick(3);
        chk("rst_valid", rx.valid, 0);
        chk("rst_data", rx.data, 0);
        chk("rst_err_frame", err_frame, 0);
        chk("rst_err_overrun", err_overrun, 0);
        rstn = 1'b1;
        tick(5);

        expect_ev(0, 8'hA5);
        t0 = cyc;
        send(8'hA5, 1'b1);
        tick(5);
        chk("t1_latency", word_cyc, t0 + 98);
        chk("t1_valid_drop", rx.valid, 0);

        rx.ready = 1'b0;
        expect_ev(0, 8'h3C);
        expect_ev(2, 8'h00);
        send(8'h3C, 1'b1);
        send(8'hC3, 1'b1);
        tick(5);
        chk("t2_valid_held", rx.valid, 1);
        chk("t2_data_kept", rx.data, 8'h3C);
        rx.ready = 1'b1;
        tick(1);
        chk("t2_valid_fall", rx.valid, 0);

        rx.ready = 1'b0;
        expect_ev(0, 8'h5A);
        send(8'h5A, 1'b1);
        expect_ev(0, 8'h96);
        fork
            send(8'h96, 1'b1);
            begin
                tick(97);
                rx.ready = 1'b1;
                tick(1);
                rx.ready = 1'b0;
            end
        join
        tick(5);
        chk("t3_valid_held", rx.valid, 1);
        chk("t3_data_new", rx.data, 8'h96);
        rx.ready = 1'b1;
        tick(2);
        chk("t3_valid_drain", rx.valid, 0);

        sig = 1'b0;
        tick(3);
        sig = 1'b1;
        tick(20);
        chk("t4_valid", rx.valid, 0);
        chk("t4_pending", exp_q.size(), 0);

        expect_ev(1, 8'h00);
        send(8'h55, 1'b0);
        tick(50);
        sig = 1'b1;
        tick(20);
        chk("t5_valid", rx.valid, 0);
        expect_ev(0, 8'h12);
        send(8'h12, 1'b1);
        tick(5);

        fork
            send(8'hFF, 1'b1);
            begin
                tick(45);
                rstn = 1'b0;
                tick(1);
                chk("t6_rst_valid", rx.valid, 0);
                chk("t6_rst_data", rx.data, 0);
                chk("t6_rst_err", {err_frame, err_overrun}, 0);
                tick(1);
                rstn = 1'b1;
            end
        join
        tick(20);
        chk("t6_no_frame", rx.valid, 0);
        expect_ev(0, 8'h81);
        send(8'h81, 1'b1);
        tick(5);

        sig  = 1'b0;
        rstn = 1'b0;
        tick(2);
        rstn = 1'b1;
        tick(30);
        sig = 1'b1;
        tick(120);
        chk("t7_low_at_reset", rx.valid, 0);
        expect_ev(0, 8'hE7);
        send(8'hE7, 1'b1);
        tick(10);
        chk("final_pending", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
